// File: rtl/id_ex_hazard_register.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional macro HAZARD_STALL_COUNT_EN adds a saturating 32-bit stall_count output.
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif

module id_ex_hazard_register #(
    parameter int REG_ADDR_WIDTH  = `NUM_REGISTERS_LOG2,
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rd,
    input  logic                      if_id_reg_write,
    input  logic                      if_id_mem_read,
    input  logic                      if_id_mem_write,
    input  logic                      flush,
    output logic                      id_ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] id_ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] id_ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
    output logic                      id_ex_reg_write,
    output logic                      id_ex_mem_read,
    output logic                      id_ex_mem_write,
    output logic                      stall
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    typedef enum logic {IDLE, STALL} state_e;

    // The load that triggered the hazard is already replaced by a bubble on
    // the first stall edge, so the remaining stall cycles come from cnt.
    localparam logic [2:0] RELOAD = 3'(LOAD_USE_CYCLES - 1);

    logic [2:0]                cnt_q, cnt_d;
    state_e                    state;
    logic                      hz;
    logic                      bubble;

    logic                      valid_q;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q, rd_q;
    logic                      reg_write_q, mem_read_q, mem_write_q;

    assign state = (cnt_q == 3'd0) ? IDLE : STALL;

    always_comb begin
        hz     = 1'b0;
        stall  = 1'b0;
        cnt_d  = cnt_q;
        bubble = 1'b0;

        hz = valid_q & mem_read_q & reg_write_q & (rd_q != '0) & if_id_valid &
             ((if_id_rs == rd_q) | (if_id_rt == rd_q));
        stall  = ~flush & (hz | (state == STALL));
        bubble = flush | stall;

        if (flush) begin
            cnt_d = 3'd0;
        end else if ((state == IDLE) && hz) begin
            cnt_d = RELOAD;
        end else if (state == STALL) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 3'd0;
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (bubble) begin
                // Zeroed addresses keep the forwarding unit from matching a bubble.
                valid_q     <= 1'b0;
                rs_q        <= '0;
                rt_q        <= '0;
                rd_q        <= '0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end else begin
                valid_q     <= if_id_valid;
                rs_q        <= if_id_rs;
                rt_q        <= if_id_rt;
                rd_q        <= if_id_rd;
                reg_write_q <= if_id_reg_write;
                mem_read_q  <= if_id_mem_read;
                mem_write_q <= if_id_mem_write;
            end
        end
    end

    assign id_ex_valid     = valid_q;
    assign id_ex_rs        = rs_q;
    assign id_ex_rt        = rt_q;
    assign id_ex_rd        = rd_q;
    assign id_ex_reg_write = reg_write_q;
    assign id_ex_mem_read  = mem_read_q;
    assign id_ex_mem_write = mem_write_q;

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    // Stall occupancy counter not built in this configuration.
`endif

endmodule

// File: tb/tb_id_ex_hazard_register.sv
// Directed bench for id_ex_hazard_register: dut_a uses 3 load-use cycles, dut_b uses 1.
`timescale 1ns/1ps

module tb_id_ex_hazard_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid, rw, mr, mw, flush;
    logic [4:0] rs, rt, rd;

    logic       a_valid, a_rw, a_mr, a_mw, a_stall;
    logic [4:0] a_rs, a_rt, a_rd;
    logic       b_valid, b_rw, b_mr, b_mw, b_stall;
    logic [4:0] b_rs, b_rt, b_rd;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] a_cnt, b_cnt;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    id_ex_hazard_register #(.REG_ADDR_WIDTH(5), .LOAD_USE_CYCLES(3)) dut_a (
        .clk(clk), .reset(reset), .if_id_valid(valid), .if_id_rs(rs), .if_id_rt(rt),
        .if_id_rd(rd), .if_id_reg_write(rw), .if_id_mem_read(mr), .if_id_mem_write(mw),
        .flush(flush), .id_ex_valid(a_valid), .id_ex_rs(a_rs), .id_ex_rt(a_rt),
        .id_ex_rd(a_rd), .id_ex_reg_write(a_rw), .id_ex_mem_read(a_mr),
        .id_ex_mem_write(a_mw), .stall(a_stall)
`ifdef HAZARD_STALL_COUNT_EN
        , .stall_count(a_cnt)
`endif
    );

    id_ex_hazard_register #(.REG_ADDR_WIDTH(5), .LOAD_USE_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .if_id_valid(valid), .if_id_rs(rs), .if_id_rt(rt),
        .if_id_rd(rd), .if_id_reg_write(rw), .if_id_mem_read(mr), .if_id_mem_write(mw),
        .flush(flush), .id_ex_valid(b_valid), .id_ex_rs(b_rs), .id_ex_rt(b_rt),
        .id_ex_rd(b_rd), .id_ex_reg_write(b_rw), .id_ex_mem_read(b_mr),
        .id_ex_mem_write(b_mw), .stall(b_stall)
`ifdef HAZARD_STALL_COUNT_EN
        , .stall_count(b_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge; sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic w, input logic r, input logic m);
        valid = v; rs = s; rt = t; rd = d; rw = w; mr = r; mw = m;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_rd", 32'(a_rd), 32'd0);
        check("rst_mr", 32'(a_mr), 32'd0);
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("rst_count", a_cnt, 32'd0);
`endif

        // Plain pass-through
        set_id(1, 3, 4, 5, 1, 0, 0);
        check("pt_stall", 32'(a_stall), 32'd0);
        step();
        check("pt_rs", 32'(a_rs), 32'd3);
        check("pt_rt", 32'(a_rt), 32'd4);
        check("pt_rd", 32'(a_rd), 32'd5);
        check("pt_rw", 32'(a_rw), 32'd1);
        check("pt_valid", 32'(a_valid), 32'd1);

        // Load-use with 3 cycles on dut_a: load rd=9, dependent rt=9, store bit set
        set_id(1, 1, 2, 9, 1, 1, 0);
        check("ld3_pre_stall", 32'(a_stall), 32'd0);
        step();
        check("ld3_ex_mr", 32'(a_mr), 32'd1);
        set_id(1, 2, 9, 10, 1, 0, 1);
        check("ld3_stall_n", 32'(a_stall), 32'd1);
        step();
        check("ld3_bub1_valid", 32'(a_valid), 32'd0);
        check("ld3_bub1_rd", 32'(a_rd), 32'd0);
        check("ld3_stall_n1", 32'(a_stall), 32'd1);
        step();
        check("ld3_bub2_valid", 32'(a_valid), 32'd0);
        check("ld3_stall_n2", 32'(a_stall), 32'd1);
        step();
        check("ld3_bub3_valid", 32'(a_valid), 32'd0);
        check("ld3_bub3_rt", 32'(a_rt), 32'd0);
        check("ld3_stall_n3", 32'(a_stall), 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("ld3_count", a_cnt, 32'd3);
`endif
        step();
        check("ld3_cap_rd", 32'(a_rd), 32'd10);
        check("ld3_cap_rt", 32'(a_rt), 32'd9);
        check("ld3_cap_mw", 32'(a_mw), 32'd1);
        check("ld3_cap_valid", 32'(a_valid), 32'd1);

        // Load-use with 1 cycle on dut_b: load rd=7, dependent rs=7
        set_id(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        set_id(1, 0, 0, 7, 1, 1, 0);
        step();
        set_id(1, 7, 0, 8, 1, 0, 0);
        check("ld1_stall", 32'(b_stall), 32'd1);
        step();
        check("ld1_bub_valid", 32'(b_valid), 32'd0);
        check("ld1_bub_rd", 32'(b_rd), 32'd0);
        check("ld1_stall_end", 32'(b_stall), 32'd0);
        step();
        check("ld1_cap_rd", 32'(b_rd), 32'd8);
        check("ld1_cap_rs", 32'(b_rs), 32'd7);
        check("ld1_cap_valid", 32'(b_valid), 32'd1);

        // Register-zero immunity on dut_b
        set_id(1, 0, 0, 0, 1, 1, 0);
        step();
        set_id(1, 0, 5, 6, 1, 0, 0);
        check("r0_stall", 32'(b_stall), 32'd0);
        step();
        check("r0_cap_rd", 32'(b_rd), 32'd6);
        check("r0_cap_valid", 32'(b_valid), 32'd1);

        // Invalid ID instruction raises no hazard but still passes through
        set_id(1, 0, 0, 7, 1, 1, 0);
        step();
        set_id(0, 7, 0, 8, 1, 0, 0);
        check("inv_stall", 32'(b_stall), 32'd0);
        step();
        check("inv_valid", 32'(b_valid), 32'd0);
        check("inv_rd", 32'(b_rd), 32'd8);

        // Flush together with a hazard on dut_a
        set_id(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        set_id(1, 0, 0, 9, 1, 1, 0);
        step();
        set_id(1, 9, 0, 11, 1, 0, 0);
        flush = 1'b1;
        #1;
        check("fh_stall", 32'(a_stall), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fh_bub_valid", 32'(a_valid), 32'd0);
        check("fh_bub_rd", 32'(a_rd), 32'd0);
        check("fh_stall_after", 32'(a_stall), 32'd0);
        step();
        check("fh_cap_rd", 32'(a_rd), 32'd11);

        // Flush at the second cycle of a 3-cycle stall
        set_id(1, 0, 0, 9, 1, 1, 0);
        step();
        set_id(1, 9, 0, 12, 1, 0, 0);
        check("fs_stall_n", 32'(a_stall), 32'd1);
        step();
        flush = 1'b1;
        #1;
        check("fs_stall_flush", 32'(a_stall), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fs_bub_valid", 32'(a_valid), 32'd0);
        check("fs_stall_after", 32'(a_stall), 32'd0);
        step();
        check("fs_cap_rd", 32'(a_rd), 32'd12);
        check("fs_cap_valid", 32'(a_valid), 32'd1);

        // Reset in the middle of a stall
        set_id(1, 0, 0, 9, 1, 1, 0);
        step();
        set_id(1, 9, 0, 13, 1, 0, 0);
        step();
        check("rs_mid_stall", 32'(a_stall), 32'd1);
        do_reset();
        #1;
        check("rs_valid", 32'(a_valid), 32'd0);
        check("rs_rd", 32'(a_rd), 32'd0);
        check("rs_rs", 32'(a_rs), 32'd0);
        check("rs_stall", 32'(a_stall), 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("rs_count", a_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_hazard_register.md
# id_ex_hazard_register

ID/EX pipeline register with integrated load-use hazard detection and bubble insertion. It captures decoded register addresses and control bits from the ID stage and presents them as the registered `id_ex_*` fields. The forwarding unit and EX stage consume these fields. When a load in EX is followed by a dependent instruction in ID, the block stalls IF/ID and injects bubbles for a configurable number of cycles. It also squashes ID/EX on a branch flush.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, default `` `NUM_REGISTERS_LOG2 ``, register address width.
- `LOAD_USE_CYCLES`, default 1, range 1..7, bubbles inserted per load-use hazard.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset`, in, 1, synchronous, active-high.
- `if_id_valid`, in, 1, ID-stage instruction is valid.
- `if_id_rs`, in, REG_ADDR_WIDTH, ID source A.
- `if_id_rt`, in, REG_ADDR_WIDTH, ID source B.
- `if_id_rd`, in, REG_ADDR_WIDTH, ID destination.
- `if_id_reg_write`, in, 1, ID instruction writes `rd`.
- `if_id_mem_read`, in, 1, ID instruction is a load.
- `if_id_mem_write`, in, 1, ID instruction is a store.
- `flush`, in, 1, branch/jump resolved taken; squash ID.
- `id_ex_valid`, out, 1, registered.
- `id_ex_rs`, out, REG_ADDR_WIDTH, registered.
- `id_ex_rt`, out, REG_ADDR_WIDTH, registered.
- `id_ex_rd`, out, REG_ADDR_WIDTH, registered.
- `id_ex_reg_write`, out, 1, registered.
- `id_ex_mem_read`, out, 1, registered.
- `id_ex_mem_write`, out, 1, registered.
- `stall`, out, 1, combinational; holds PC and IF/ID when high.
- `stall_count`, out, 32, present only with `HAZARD_STALL_COUNT_EN`.

## Operation
- **Hazard term:** `hz = id_ex_valid & id_ex_mem_read & id_ex_reg_write & (id_ex_rd != 0) & if_id_valid & ((if_id_rs == id_ex_rd) | (if_id_rt == id_ex_rd))`.
- **State machine:** 3-bit down-counter `cnt`.
  - IDLE when `cnt == 0`; STALL when `cnt != 0`.
  - `stall = ~flush & (hz | (cnt != 0))`.
- **Counter update, in priority order:**
  - `flush` → `cnt <= 0`.
  - IDLE & `hz` → `cnt <= LOAD_USE_CYCLES-1`, entering STALL if that value is nonzero.
  - STALL → `cnt <= cnt-1`.
- **Register update, in priority order:**
  - `reset` → all outputs 0.
  - `flush` or `stall` → bubble: `id_ex_valid`, `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write` <= 0. `rs`, `rt` and `rd` also go to 0, so forwarding never matches a bubble.
  - Otherwise, capture all `if_id_*` fields.
- **Register 0:** `rd == 0` never causes a hazard.
- **Stores:** a store whose `rt` depends on the load still stalls; there is no special-case store-data bypass.
- **Flush during STALL:** aborts the stall immediately.
- **Invalid ID instruction:** when `if_id_valid = 0`, no hazard is raised. The instruction is still captured, so `id_ex_valid = 0` passes through.

## Timing
- **Reset:** all registered outputs 0, `cnt` = 0, `stall` = 0 in the cycle after the reset edge. `stall_count` = 0.
- **Latency:** ID→EX is 1 cycle.
- **`stall` path:** combinational from registered state and the `if_id_*`/`flush` inputs, with no dependence on its own value.
- **Load-use timing:** a load in EX with a dependent instruction in ID at cycle N gives:
  - `stall` high for cycles N..N+LOAD_USE_CYCLES-1.
  - Bubbles in ID/EX for cycles N+1..N+LOAD_USE_CYCLES.
  - The dependent instruction enters ID/EX at the edge ending cycle N+LOAD_USE_CYCLES.
- **Back-to-back loads:** handled the same way. A second dependent load-use is detected in IDLE after the first bubble drains.
- **Simultaneous `flush` and `hz`:** `flush` wins; no stall, bubble loaded.
- **`reset` mid-stall:** `cnt` cleared, `stall` low the next cycle.

## Configuration
- **Macro:** `HAZARD_STALL_COUNT_EN`.
- **Defined:** adds the 32-bit `stall_count` output.
  - Increments on every cycle with `stall = 1`.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by `reset`.
- **Undefined:** no port and no counter logic; behaviour is otherwise identical.

## Test plan
- **Plain pass-through:** ID presents `rs=3, rt=4, rd=5, reg_write=1`, no hazard → next cycle `id_ex_rs=3, id_ex_rt=4, id_ex_rd=5, id_ex_reg_write=1, id_ex_valid=1`; `stall` stays 0.
- **Load-use, `LOAD_USE_CYCLES=1`:** EX holds load `rd=7`, ID `rs=7` → `stall=1` for 1 cycle and one bubble (`id_ex_valid=0, id_ex_rd=0`). Next cycle, ID instruction is captured with `stall=0`.
- **Load-use, `LOAD_USE_CYCLES=3`:** EX holds load `rd=9`, ID `rt=9` → `stall` high for exactly 3 cycles and 3 consecutive bubbles. With `HAZARD_STALL_COUNT_EN`, `stall_count` = 3.
- **Register-zero immunity:** EX holds load `rd=0`, ID `rs=0` → `stall=0` and the instruction is captured.
- **Flush priority:** `flush=1` in the same cycle as a hazard, and also at the second cycle of a 3-cycle STALL → `stall=0` that cycle, bubble loaded, `cnt=0` afterwards.
- **Reset mid-stall:** assert `reset` during STALL → next cycle all outputs 0, `stall=0`, `stall_count=0`.
